// File: rtl/buzzer_pkg.sv
// Shared types and constants for the buzzer sequencer: FSM states, sound ids,
// tone half-periods (in clocks at 25 MHz), note/gap lengths and the win melody.
package buzzer_pkg;

  localparam int unsigned HP_W  = 16;
  localparam int unsigned LEN_W = 8;
  localparam int unsigned WIN_NOTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Encoding order doubles as priority: higher value wins.
  typedef enum logic [1:0] {
    SND_NONE  = 2'd0,
    SND_DROP  = 2'd1,
    SND_ERROR = 2'd2,
    SND_WIN   = 2'd3
  } sound_t;

  localparam logic [HP_W-1:0] HP_C5  = 16'd23889;
  localparam logic [HP_W-1:0] HP_E5  = 16'd18961;
  localparam logic [HP_W-1:0] HP_G5  = 16'd15944;
  localparam logic [HP_W-1:0] HP_C6  = 16'd11945;
  localparam logic [HP_W-1:0] HP_ERR = 16'd62500;

  localparam logic [LEN_W-1:0] LEN_DROP       = 8'd16;
  localparam logic [LEN_W-1:0] LEN_ERROR      = 8'd32;
  localparam logic [LEN_W-1:0] LEN_WIN_NOTE   = 8'd24;
  localparam logic [LEN_W-1:0] LEN_WIN_GAP    = 8'd4;
  localparam logic [LEN_W-1:0] LEN_WIN_SINGLE = 8'd96;

  // Win melody table: C5, E5, G5, C6.
  function automatic logic [HP_W-1:0] win_half_period(input logic [1:0] idx);
    case (idx)
      2'd0:    win_half_period = HP_C5;
      2'd1:    win_half_period = HP_E5;
      2'd2:    win_half_period = HP_G5;
      default: win_half_period = HP_C6;
    endcase
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone generator: divider counts 0..half_period-1, tone toggles on wrap.
module tone_gen
  import buzzer_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic [HP_W-1:0] half_period,
  output logic            tone
);

  logic [HP_W-1:0] cnt;
  logic            wrap;

  assign wrap = (cnt == HP_W'(half_period - 16'd1));

  // Divider and tone bit; clear restarts the phase at 0.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      tone <= ~tone;
    end else begin
      cnt  <= cnt + HP_W'(1);
    end
  end

endmodule

// File: rtl/buzzer_sequencer.sv
// Piezo buzzer sequencer for drop / error / win sounds with priority preemption.
// BUZZER_WIN_MELODY_EN: when defined, win plays a 4-note melody with gaps;
// otherwise win is a single long C6 note.
module buzzer_sequencer
  import buzzer_pkg::*;
#(
  parameter int unsigned UNIT_SHIFT = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic snd_drop,
  input  logic snd_error,
  input  logic snd_win,
  input  logic mute,
  output logic buzzer_out,
  output logic busy
);

  state_t                state, state_n;
  sound_t                snd, snd_n, trig;
  logic [UNIT_SHIFT-1:0] pre, pre_n;
  logic [LEN_W-1:0]      unit_cnt, unit_n;
  logic [HP_W-1:0]       cur_hp;
  logic [LEN_W-1:0]      cur_len;
  logic                  start, unit_tick, last_unit, restart, tone;
`ifdef BUZZER_WIN_MELODY_EN
  logic [1:0]            note_idx, idx_n;
`endif

  // Highest-priority trigger this cycle.
  always_comb begin
    trig = SND_NONE;
    if (snd_win)        trig = SND_WIN;
    else if (snd_error) trig = SND_ERROR;
    else if (snd_drop)  trig = SND_DROP;
  end

  assign start = (trig != SND_NONE) && ((state == IDLE) || (2'(trig) > 2'(snd)));

  // Tone and length of the note currently selected.
  always_comb begin
    cur_hp  = HP_C6;
    cur_len = LEN_DROP;
    case (snd)
      SND_ERROR: begin
        cur_hp  = HP_ERR;
        cur_len = LEN_ERROR;
      end
      SND_WIN: begin
`ifdef BUZZER_WIN_MELODY_EN
        cur_hp  = win_half_period(note_idx);
        cur_len = LEN_WIN_NOTE;
`else
        cur_hp  = HP_C6;
        cur_len = LEN_WIN_SINGLE;
`endif
      end
      default: begin
        cur_hp  = HP_C6;
        cur_len = LEN_DROP;
      end
    endcase
  end

  assign unit_tick = &pre;
  assign last_unit = unit_tick &&
                     (unit_cnt == LEN_W'(((state == GAP) ? LEN_WIN_GAP : cur_len) - 8'd1));

  // Next-state, counters and divider restart.
  always_comb begin
    state_n = state;
    snd_n   = snd;
    pre_n   = pre;
    unit_n  = unit_cnt;
    restart = 1'b0;
`ifdef BUZZER_WIN_MELODY_EN
    idx_n   = note_idx;
`endif
    if (start) begin
      state_n = NOTE;
      snd_n   = trig;
      pre_n   = '0;
      unit_n  = '0;
      restart = 1'b1;
`ifdef BUZZER_WIN_MELODY_EN
      idx_n   = 2'd0;
`endif
    end else begin
      case (state)
        NOTE: begin
          pre_n = pre + UNIT_SHIFT'(1);
          if (last_unit) begin
            unit_n  = '0;
            restart = 1'b1;
            state_n = IDLE;
            snd_n   = SND_NONE;
`ifdef BUZZER_WIN_MELODY_EN
            if (snd == SND_WIN && note_idx != 2'(WIN_NOTES - 1)) begin
              state_n = GAP;
              snd_n   = snd;
            end
`endif
          end else if (unit_tick) begin
            unit_n = unit_cnt + LEN_W'(1);
          end
        end
        GAP: begin
          restart = 1'b1;
`ifdef BUZZER_WIN_MELODY_EN
          pre_n = pre + UNIT_SHIFT'(1);
          if (last_unit) begin
            unit_n  = '0;
            state_n = NOTE;
            idx_n   = note_idx + 2'd1;
          end else if (unit_tick) begin
            unit_n = unit_cnt + LEN_W'(1);
          end
`else
          pre_n   = '0;
          unit_n  = '0;
          state_n = IDLE;
          snd_n   = SND_NONE;
`endif
        end
        default: begin
          restart = 1'b1;
          pre_n   = '0;
          unit_n  = '0;
          state_n = IDLE;
          snd_n   = SND_NONE;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      snd      <= SND_NONE;
      pre      <= '0;
      unit_cnt <= '0;
`ifdef BUZZER_WIN_MELODY_EN
      note_idx <= 2'd0;
`endif
    end else begin
      state    <= state_n;
      snd      <= snd_n;
      pre      <= pre_n;
      unit_cnt <= unit_n;
`ifdef BUZZER_WIN_MELODY_EN
      note_idx <= idx_n;
`endif
    end
  end

  tone_gen u_tone (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (restart),
    .half_period(cur_hp),
    .tone       (tone)
  );

  assign buzzer_out = tone & ~mute & (state == NOTE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Directed self-checking bench: instance A (unit = 16 clocks) checks sequencing,
// priority and reset; instance B (unit = 2048 clocks) checks tone timing and mute.
module tb_buzzer_sequencer;
  import buzzer_pkg::*;

`ifdef BUZZER_WIN_MELODY_EN
  localparam int EXP_WIN_LEN   = 1728;
  localparam int EXP_WIN_NOTES = 4;
  localparam int EXP_WIN_GAP   = 192;
  localparam int EXP_NOTE_LEN  = 384;
`else
  localparam int EXP_WIN_LEN   = 1536;
  localparam int EXP_WIN_NOTES = 1;
  localparam int EXP_WIN_GAP   = 0;
  localparam int EXP_NOTE_LEN  = 1536;
`endif

  logic clk;
  logic rst_a, drop_a, err_a, win_a, mute_a, buzz_a, busy_a;
  logic rst_b, drop_b, err_b, win_b, mute_b, buzz_b, busy_b;
  logic done_b;

  int n_vec = 0;
  int n_miss = 0;
  int exp_hp[4];

  int m_len, m_notes, m_gap, m_high;
  int m_hp[4];
  int m_nlen[4];
  int b_len, b_rise, b_fall, b_rises, b_high;

  buzzer_sequencer #(.UNIT_SHIFT(4)) dut_a (
    .clk(clk), .rst_n(rst_a), .snd_drop(drop_a), .snd_error(err_a),
    .snd_win(win_a), .mute(mute_a), .buzzer_out(buzz_a), .busy(busy_a)
  );

  buzzer_sequencer #(.UNIT_SHIFT(11)) dut_b (
    .clk(clk), .rst_n(rst_b), .snd_drop(drop_b), .snd_error(err_b),
    .snd_win(win_b), .mute(mute_b), .buzzer_out(buzz_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  // Pulse {win,err,drop} for one cycle on A; returns at the first cycle of the response.
  task automatic pulse_a(input logic [2:0] trg, input string tag);
    {win_a, err_a, drop_a} = trg;
    @(negedge clk);
    {win_a, err_a, drop_a} = 3'b000;
    check_eq(tag, int'(busy_a), 1);
  endtask

  // Follow an A sound until idle; optionally inject a trigger at cycle inj_at.
  task automatic measure_a(input int limit, input int inj_at, input logic [2:0] inj);
    int seg;
    m_len = 0; m_notes = 0; m_gap = 0; m_high = 0; seg = 0;
    for (int i = 0; i < 4; i++) begin
      m_hp[i] = 0;
      m_nlen[i] = 0;
    end
    while (busy_a && m_len < limit) begin
      if (dut_a.state == NOTE) begin
        if (seg == 0) begin
          if (m_notes < 4) m_hp[m_notes] = int'(dut_a.cur_hp);
          m_notes++;
        end
        seg++;
      end else begin
        if (seg != 0 && m_notes >= 1 && m_notes <= 4) m_nlen[m_notes-1] = seg;
        seg = 0;
        m_gap++;
      end
      if (buzz_a) m_high++;
      {win_a, err_a, drop_a} = (m_len == inj_at) ? inj : 3'b000;
      m_len++;
      @(negedge clk);
    end
    {win_a, err_a, drop_a} = 3'b000;
    if (seg != 0 && m_notes >= 1 && m_notes <= 4) m_nlen[m_notes-1] = seg;
    check_eq("a_within_bound", int'(m_len < limit), 1);
  endtask

  // Follow a B drop sound, recording tone edges; optional mute window.
  task automatic measure_b(input logic use_mute);
    logic prev;
    prev = 1'b0;
    b_len = 0; b_rise = -1; b_fall = -1; b_rises = 0; b_high = 0;
    while (busy_b && b_len < 40000) begin
      if (buzz_b && !prev) begin
        b_rises++;
        if (b_rise < 0) b_rise = b_len;
      end
      if (!buzz_b && prev && b_fall < 0) b_fall = b_len;
      if (buzz_b) b_high++;
      prev = buzz_b;
      mute_b = use_mute && (b_len >= 4999) && (b_len < 14999);
      b_len++;
      @(negedge clk);
    end
    mute_b = 1'b0;
    check_eq("b_within_bound", int'(b_len < 40000), 1);
  endtask

  // Instance B: tone timing and mute phase.
  initial begin
    done_b = 1'b0;
    rst_b = 1'b0; drop_b = 1'b0; err_b = 1'b0; win_b = 1'b0; mute_b = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("b_rst_busy", int'(busy_b), 0);
    rst_b = 1'b1;
    @(negedge clk);

    drop_b = 1'b1;
    @(negedge clk);
    drop_b = 1'b0;
    check_eq("b_drop_busy_next", int'(busy_b), 1);
    measure_b(1'b0);
    check_eq("b_drop_len", b_len, 32768);
    check_eq("b_first_rise", b_rise, 11945);
    check_eq("b_first_fall", b_fall, 23890);
    check_eq("b_rises", b_rises, 1);
    check_eq("b_high", b_high, 11945);

    drop_b = 1'b1;
    @(negedge clk);
    drop_b = 1'b0;
    measure_b(1'b1);
    check_eq("b_mute_len", b_len, 32768);
    check_eq("b_mute_rise", b_rise, 15000);
    check_eq("b_mute_fall", b_fall, 23890);
    check_eq("b_mute_high", b_high, 8890);
    done_b = 1'b1;
  end

  // Instance A: sequencing, priority, preemption, reset.
  initial begin
`ifdef BUZZER_WIN_MELODY_EN
    exp_hp[0] = 23889; exp_hp[1] = 18961; exp_hp[2] = 15944; exp_hp[3] = 11945;
`else
    exp_hp[0] = 11945; exp_hp[1] = 0; exp_hp[2] = 0; exp_hp[3] = 0;
`endif
    rst_a = 1'b0; drop_a = 1'b0; err_a = 1'b0; win_a = 1'b0; mute_a = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", int'(busy_a), 0);
    check_eq("rst_buzz", int'(buzz_a), 0);
    check_eq("rst_state", int'(dut_a.state), int'(IDLE));
    rst_a = 1'b1;
    @(negedge clk);

    pulse_a(3'b001, "drop_busy_next");
    measure_a(4000, -1, 3'b000);
    check_eq("drop_len", m_len, 256);
    check_eq("drop_hp", m_hp[0], 11945);
    check_eq("drop_notes", m_notes, 1);
    check_eq("drop_end_buzz", int'(buzz_a), 0);

    pulse_a(3'b001, "drop2_busy_next");
    measure_a(4000, 100, 3'b001);
    check_eq("drop_retrig_len", m_len, 256);

    mute_a = 1'b1;
    pulse_a(3'b001, "mute_busy_next");
    measure_a(4000, -1, 3'b000);
    mute_a = 1'b0;
    check_eq("mute_len", m_len, 256);
    check_eq("mute_high", m_high, 0);

    pulse_a(3'b010, "err_busy_next");
    measure_a(4000, -1, 3'b000);
    check_eq("err_len", m_len, 512);
    check_eq("err_hp", m_hp[0], 62500);

    pulse_a(3'b101, "win_drop_busy_next");
    measure_a(4000, -1, 3'b000);
    check_eq("win_len", m_len, EXP_WIN_LEN);
    check_eq("win_notes", m_notes, EXP_WIN_NOTES);
    check_eq("win_gap", m_gap, EXP_WIN_GAP);
    for (int i = 0; i < EXP_WIN_NOTES; i++) begin
      check_eq($sformatf("win_hp%0d", i), m_hp[i], exp_hp[i]);
      check_eq($sformatf("win_nlen%0d", i), m_nlen[i], EXP_NOTE_LEN);
    end

    pulse_a(3'b010, "pre_err_busy");
    repeat (99) @(negedge clk);
    check_eq("pre_err_hp", int'(dut_a.cur_hp), 62500);
    pulse_a(3'b100, "pre_win_busy");
    measure_a(4000, 300, 3'b010);
    check_eq("preempt_hp", m_hp[0], exp_hp[0]);
    check_eq("preempt_len", m_len, EXP_WIN_LEN);
    check_eq("preempt_notes", m_notes, EXP_WIN_NOTES);

    pulse_a(3'b100, "rst_win_busy");
    repeat (500) @(negedge clk);
    rst_a = 1'b0;
    drop_a = 1'b1;
    @(negedge clk);
    check_eq("midrst_busy", int'(busy_a), 0);
    check_eq("midrst_buzz", int'(buzz_a), 0);
    rst_a = 1'b1;
    drop_a = 1'b0;
    @(negedge clk);
    check_eq("rst_trig_ignored", int'(busy_a), 0);
    pulse_a(3'b001, "post_rst_busy");
    measure_a(4000, -1, 3'b000);
    check_eq("post_rst_len", m_len, 256);

    while (!done_b) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
